// File: rtl/otter_branch_predictor.sv
// otter_branch_predictor: direct-mapped BTB with 2-bit direction counters.
// Ports: CLK/RST; fetch lookup (if_pc -> if_pred_taken/if_pred_target, zero latency);
//        execute resolution (ex_* -> mispredict/redirect_pc, combinational; state updated at posedge CLK);
//        perf_branches/perf_mispredicts saturating event counters.
module otter_branch_predictor #(
  parameter int ENTRIES      = 16,
  parameter bit PREDICT_JALR = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_target,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic [1:0]       ex_type,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    T_NONE   = 2'b00,
    T_BRANCH = 2'b01,
    T_JAL    = 2'b10,
    T_JALR   = 2'b11
  } ex_type_t;

  // Entry storage. Only valid/ctr/is_jump need a reset value; a stale tag or
  // target behind a cleared valid bit can never be observed.
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  // ---------------- fetch lookup ----------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  // Jumps are always taken once known; branches follow the counter MSB.
  assign if_pred_taken  = if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
  assign if_pred_target = if_pred_taken ? tgt_q[if_idx] : 32'd0;

  // Instruction-alignment bits do not take part in indexing or tagging.
  logic unused_if_lsb;
  assign unused_if_lsb = &{1'b0, if_pc[1:0]};

  // ---------------- execute resolution ----------------
  logic             qual;
  logic             upd_en;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ex_is_branch;

  assign ex_idx       = ex_pc[IDX_W+1:2];
  assign ex_tag       = ex_pc[31:IDX_W+2];
  assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_is_branch = (ex_type == T_BRANCH);

  // RST in the qualifier forces the combinational outputs low immediately
  // and discards any update presented while reset is held.
  assign qual   = ex_valid && (ex_type != T_NONE) && !RST;
  assign upd_en = qual && !((ex_type == T_JALR) && !PREDICT_JALR);

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = 32'd0;
    if (qual) begin
      mispredict  = (ex_taken != ex_pred_taken) ||
                    (ex_taken && (ex_target != ex_pred_target));
      redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
    end
  end

  // ---------------- state update ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_en) begin
      if (ex_hit) begin
        // The entry kind follows the most recent resolution at this PC.
        jump_q[ex_idx] <= !ex_is_branch;
        if (ex_is_branch) begin
          if (ex_taken && (ctr_q[ex_idx] != 2'b11)) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
          end else if (!ex_taken && (ctr_q[ex_idx] != 2'b00)) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
          end
        end
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        jump_q[ex_idx]  <= !ex_is_branch;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target arrays carry no reset; writes are still gated by upd_en,
  // which is low while RST is asserted.
  always_ff @(posedge CLK) begin
    if (upd_en && !ex_hit && ex_taken) begin
      tag_q[ex_idx] <= ex_tag;
    end
    // Covers both allocation and the target refresh of a taken hit.
    if (upd_en && ex_taken) begin
      tgt_q[ex_idx] <= ex_target;
    end
  end

  // ---------------- performance counters ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (qual) begin
      if (perf_branches != '1) begin
        perf_branches <= perf_branches + 1'b1;
      end
      if (mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Directed bench for otter_branch_predictor: two instances share stimulus
// (d0: PREDICT_JALR=0, CNT_W=4; d1: PREDICT_JALR=1, CNT_W=16).
// Expected values are queued per cycle; a negedge monitor pops and compares.
module tb_otter_branch_predictor;

  logic        CLK;
  logic        RST;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_type;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        d0_pt, d1_pt, d0_mp, d1_mp;
  logic [31:0] d0_ptgt, d1_ptgt, d0_rd, d1_rd;
  logic [3:0]  d0_pb, d0_pm;
  logic [15:0] d1_pb, d1_pm;

  otter_branch_predictor #(.ENTRIES(16), .PREDICT_JALR(1'b0), .CNT_W(4)) dut0 (
    .CLK(CLK), .RST(RST), .if_pc(if_pc),
    .if_pred_taken(d0_pt), .if_pred_target(d0_ptgt),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_type(ex_type), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(d0_mp), .redirect_pc(d0_rd),
    .perf_branches(d0_pb), .perf_mispredicts(d0_pm)
  );

  otter_branch_predictor #(.ENTRIES(16), .PREDICT_JALR(1'b1), .CNT_W(16)) dut1 (
    .CLK(CLK), .RST(RST), .if_pc(if_pc),
    .if_pred_taken(d1_pt), .if_pred_target(d1_ptgt),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_type(ex_type), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(d1_mp), .redirect_pc(d1_rd),
    .perf_branches(d1_pb), .perf_mispredicts(d1_pm)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Field codes for expectations.
  localparam int F_PT = 0, F_PTGT = 1, F_MP = 2, F_RD = 3, F_PB = 4, F_PM = 5;

  typedef struct {
    int          cyc;
    int          d;
    int          f;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge CLK) cyc++;

  function automatic logic [31:0] observe(input int d, input int f);
    logic [31:0] v;
    v = 32'd0;
    case (f)
      F_PT:   v = (d == 0) ? {31'd0, d0_pt} : {31'd0, d1_pt};
      F_PTGT: v = (d == 0) ? d0_ptgt : d1_ptgt;
      F_MP:   v = (d == 0) ? {31'd0, d0_mp} : {31'd0, d1_mp};
      F_RD:   v = (d == 0) ? d0_rd : d1_rd;
      F_PB:   v = (d == 0) ? {28'd0, d0_pb} : {16'd0, d1_pb};
      F_PM:   v = (d == 0) ? {28'd0, d0_pm} : {16'd0, d1_pm};
      default: v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  // Monitor: outputs are combinational, so each cycle's expectations are
  // checked on the falling edge of the cycle they were issued in.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s (d%0d): expectation for cycle %0d never sampled", e.name, e.d, e.cyc);
      end else begin
        act = observe(e.d, e.f);
        if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s (d%0d): got 0x%0h, expected 0x%0h", e.name, e.d, act, e.val);
        end
      end
    end
  end

  task automatic expect_v(input int d, input int f, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.d = d; e.f = f; e.val = v; e.name = name;
    q.push_back(e);
  endtask

  // Same expectation on both instances.
  task automatic expect2(input int f, input logic [31:0] v, input string name);
    expect_v(0, f, v, name);
    expect_v(1, f, v, name);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_pc = 32'd0; ex_type = 2'b00; ex_taken = 1'b0;
    ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
  endtask

  task automatic res(input logic [1:0] t, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_type = t; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    if_pc = 32'd0;
    idle();
    repeat (3) nxt();
    RST = 1'b0;

    // Post-reset lookup and counters.
    if_pc = 32'h44;
    expect2(F_PT, 0, "rst_pred");
    expect2(F_PTGT, 0, "rst_tgt");
    expect2(F_PB, 0, "rst_pb");
    expect2(F_PM, 0, "rst_pm");
    expect2(F_MP, 0, "rst_mp");
    expect2(F_RD, 0, "rst_rd");
    nxt();

    // Taken branch, predicted not-taken; same-index lookup sees pre-update state.
    res(2'b01, 32'h44, 1'b1, 32'h20, 1'b0, 32'h0);
    expect2(F_MP, 1, "br_alloc_mp");
    expect2(F_RD, 32'h20, "br_alloc_rd");
    expect2(F_PT, 0, "rbw_pred");
    nxt();
    idle();
    expect2(F_PT, 1, "br_hit_pred");
    expect2(F_PTGT, 32'h20, "br_hit_tgt");
    expect2(F_PB, 1, "pb_1");
    expect2(F_PM, 1, "pm_1");
    nxt();

    // Not taken while predicted taken: ctr 10 -> 01.
    res(2'b01, 32'h44, 1'b0, 32'h20, 1'b1, 32'h20);
    expect2(F_MP, 1, "br_nt1_mp");
    expect2(F_RD, 32'h48, "br_nt1_rd");
    nxt();
    // Not taken again, predicted not-taken: ctr 01 -> 00.
    res(2'b01, 32'h44, 1'b0, 32'h20, 1'b0, 32'h0);
    expect2(F_PT, 0, "weak_nt_pred");
    expect2(F_MP, 0, "br_nt2_mp");
    expect2(F_RD, 32'h48, "br_nt2_rd");
    nxt();
    idle();
    expect2(F_PT, 0, "strong_nt_pred");
    expect2(F_PTGT, 0, "strong_nt_tgt");
    expect2(F_PB, 3, "pb_3");
    expect2(F_PM, 2, "pm_2");
    nxt();

    // Alias: 0x44 and 0x84 share index 1.
    res(2'b10, 32'h44, 1'b1, 32'h100, 1'b0, 32'h0);
    expect2(F_MP, 1, "jal44_mp");
    expect2(F_RD, 32'h100, "jal44_rd");
    nxt();
    res(2'b10, 32'h84, 1'b1, 32'h200, 1'b0, 32'h0);
    expect2(F_MP, 1, "jal84_mp");
    expect2(F_RD, 32'h200, "jal84_rd");
    nxt();
    idle();
    expect2(F_PT, 0, "alias_evict_pred");
    expect2(F_PTGT, 0, "alias_evict_tgt");
    nxt();
    if_pc = 32'h84;
    expect2(F_PT, 1, "alias_new_pred");
    expect2(F_PTGT, 32'h200, "alias_new_tgt");
    nxt();

    // Correct prediction, then target mismatch with matching direction.
    res(2'b10, 32'h84, 1'b1, 32'h200, 1'b1, 32'h200);
    expect2(F_MP, 0, "jal_ok_mp");
    expect2(F_RD, 32'h200, "jal_ok_rd");
    nxt();
    res(2'b10, 32'h84, 1'b1, 32'h300, 1'b1, 32'h200);
    expect2(F_MP, 1, "jal_tgt_mp");
    expect2(F_RD, 32'h300, "jal_tgt_rd");
    nxt();
    idle();
    expect2(F_PTGT, 32'h300, "jal_tgt_upd");
    nxt();

    // JALR: d0 never allocates, d1 predicts like JAL.
    res(2'b11, 32'h30, 1'b1, 32'h80, 1'b0, 32'h0);
    expect2(F_MP, 1, "jalr_mp");
    expect2(F_RD, 32'h80, "jalr_rd");
    nxt();
    idle();
    if_pc = 32'h30;
    expect_v(0, F_PT, 0, "jalr_noalloc_pred");
    expect_v(0, F_PTGT, 0, "jalr_noalloc_tgt");
    expect_v(1, F_PT, 1, "jalr_alloc_pred");
    expect_v(1, F_PTGT, 32'h80, "jalr_alloc_tgt");
    expect2(F_PB, 8, "pb_8");
    expect2(F_PM, 6, "pm_6");
    nxt();

    // 20 mispredicting resolutions: d0 counters saturate at 0xF.
    for (int i = 0; i < 20; i++) begin
      res(2'b01, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h0);
      nxt();
    end
    idle();
    expect_v(0, F_PB, 32'hF, "sat_pb");
    expect_v(0, F_PM, 32'hF, "sat_pm");
    expect_v(1, F_PB, 28, "nosat_pb");
    expect_v(1, F_PM, 26, "nosat_pm");
    nxt();

    // Reset asserted mid-cycle during an update.
    if_pc = 32'h84;
    res(2'b01, 32'h50, 1'b1, 32'h60, 1'b0, 32'h0);
    #1;
    RST = 1'b1;
    expect2(F_MP, 0, "rst_mid_mp");
    expect2(F_RD, 0, "rst_mid_rd");
    expect2(F_PT, 0, "rst_mid_pred");
    expect2(F_PTGT, 0, "rst_mid_tgt");
    expect2(F_PB, 0, "rst_mid_pb");
    expect2(F_PM, 0, "rst_mid_pm");
    nxt();
    RST = 1'b0;
    idle();
    if_pc = 32'h50;
    expect2(F_PT, 0, "rst_discard_pred");
    expect2(F_PB, 0, "rst_discard_pb");
    nxt();

    nxt();
    nxt();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s (d%0d): expectation left unchecked", e.name, e.d);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/otter_branch_predictor.md
Name: otter_branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters for the five-stage OTTER pipeline.
- Fetch queries it combinationally with the current PC to choose the next PC.
- Execute reports each resolved control-flow instruction. The block updates its state, flags mispredictions and supplies the corrective redirect PC.
- It replaces fixed "predict not-taken, flush on taken" handling; a correct prediction costs zero bubbles.

Parameters:
- ENTRIES, 16, number of BTB entries; power of 2, range 4..256.
- PREDICT_JALR, 0, 1 = JALR is allocated and predicted like JAL; 0 = JALR is never allocated and always resolves as a mispredict when taken.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- CLK, input, 1, clock.
- RST, input, 1, asynchronous active-high reset.
- if_pc, input, 32, PC being fetched.
- if_pred_taken, output, 1, predict redirect for if_pc.
- if_pred_target, output, 32, predicted target; 0 when if_pred_taken=0.
- ex_valid, input, 1, execute holds a resolved instruction; low for bubbles and flushes.
- ex_pc, input, 32, PC of the execute instruction.
- ex_type, input, 2, 00 none, 01 BRANCH, 10 JAL, 11 JALR.
- ex_taken, input, 1, actual outcome (1 for JAL and JALR).
- ex_target, input, 32, actual target address.
- ex_pred_taken, input, 1, prediction that was made at fetch, carried down the pipeline.
- ex_pred_target, input, 32, predicted target carried down the pipeline.
- mispredict, output, 1, flush fetch and decode, then redirect.
- redirect_pc, output, 32, correct next PC when mispredict=1.
- perf_branches, output, CNT_W, resolved control-flow count.
- perf_mispredicts, output, CNT_W, mispredict count.

Behaviour:
- Widths and fields:
  - IDX_W = log2(ENTRIES).
  - Index = pc[IDX_W+1:2].
  - Tag = pc[31:IDX_W+2], width 30-IDX_W.
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target[31:0], ctr[1:0]. Counter values: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, zero latency):
  - hit = valid && tag match.
  - JAL/JALR entries: if_pred_taken = hit, unconditionally.
  - BRANCH entries: if_pred_taken = hit && ctr[1].
  - Entries store a 1-bit is_jump flag to distinguish the two cases.
- Resolution (combinational) applies only when ex_valid=1 and ex_type != 00:
  - mispredict = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - Otherwise mispredict=0 and redirect_pc=0.
- Update (registered at posedge CLK, same gating):
  - Hit, BRANCH: ctr saturates toward ex_taken; target <= ex_target when taken.
  - Hit, JAL: target <= ex_target; ctr unchanged.
  - Miss, taken: allocate, overwriting any aliased entry. Set valid=1, new tag, target=ex_target, ctr=10, is_jump=(ex_type!=01).
  - Miss, not taken: no allocation.
  - JALR with PREDICT_JALR=0: no allocation or update. It still counts toward the perf counters and mispredict.
- Read-before-write: a lookup of the same index in the cycle it is updated returns the pre-update entry. The new state is visible the following cycle.
- Performance counters:
  - perf_branches increments on every qualified resolution.
  - perf_mispredicts increments when mispredict=1.
  - Both saturate at all-ones and do not wrap.
- Reset (asynchronous, any time including mid-update):
  - All valid bits 0; ctr 01; is_jump 0.
  - Perf counters 0.
  - Outputs immediately: if_pred_taken=0, if_pred_target=0, mispredict=0, redirect_pc=0.
  - Target and tag arrays need not be cleared.
  - An update presented while RST is high is discarded.
- Stalls: the block has no stall input. The pipeline holds ex_valid low or keeps fetch PC steady. Repeated ex_valid=1 for one instruction counts twice; the pipeline must not do this.

Test Plan:
- Reset, then lookup if_pc=0x44 -> if_pred_taken=0, if_pred_target=0; both perf counters 0.
- Resolve BRANCH pc=0x44, taken, target=0x20, pred_taken=0 -> mispredict=1, redirect_pc=0x20. Next cycle lookup 0x44 -> pred_taken=1, target=0x20, ctr=10.
- Same branch resolved not-taken twice (pred_taken=1, then 0) -> first: mispredict=1, redirect_pc=0x48, ctr 10->01; second: mispredict=0, ctr 01->00. Lookup 0x44 -> pred_taken=0.
- Alias (ENTRIES=16): allocate JAL pc=0x44 -> target 0x100, then taken JAL pc=0x84 -> target 0x200 -> lookup 0x44 misses (pred 0); lookup 0x84 -> pred_taken=1, target=0x200.
- JALR pc=0x30, target=0x80, PREDICT_JALR=0 -> mispredict=1, redirect_pc=0x80, no allocation, 0x30 lookup misses. Same stimulus with PREDICT_JALR=1 -> 0x30 hits next cycle.
- Saturation with CNT_W=4: 20 mispredicting resolutions -> perf_mispredicts=0xF, perf_branches=0xF. Assert RST mid-cycle during an update -> outputs go to 0 immediately and the entry stays invalid.
